logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pkg.sv | 24 ++
 rtl/logic_unit_pipe_skid_buf.sv | 78 +++++++
 rtl/logic_unit_pipe.sv | 63 ++++++
 tb/tb_logic_unit_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the pipelined bitwise logic unit.
// Opcode encoding and skid-buffer state encoding live here.
package logic_unit_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_XOR  = 3'd2;
  localparam op_t OP_NOR  = 3'd3;
  localparam op_t OP_NAND = 3'd4;
  localparam op_t OP_XNOR = 3'd5;
  localparam op_t OP_ANDN = 3'd6;
  localparam op_t OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_FULL  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/logic_unit_pipe_skid_buf.sv
// Two-entry output skid buffer with a registered in_ready.
// The head entry is always the oldest and drives out_data.
module skid_buf
  import logic_unit_pkg::*;
#(
  parameter int W = WIDTH_DEFAULT + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  sb_state_e    state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         in_ready_q, in_ready_d;
  logic         in_xfer;
  logic         out_xfer;

  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    in_xfer  = in_valid && in_ready_q;
    out_xfer = (state_q != SB_EMPTY) && out_ready;
    case (state_q)
      SB_EMPTY: begin
        if (in_xfer) begin
          head_d  = in_data;
          state_d = SB_ONE;
        end
      end
      SB_ONE: begin
        if (in_xfer && out_xfer) begin
          head_d = in_data;
        end else if (in_xfer) begin
          tail_d  = in_data;
          state_d = SB_FULL;
        end else if (out_xfer) begin
          state_d = SB_EMPTY;
        end
      end
      SB_FULL: begin
        if (out_xfer) begin
          head_d  = tail_q;
          state_d = SB_ONE;
        end
      end
      default: state_d = SB_EMPTY;
    endcase
    // Look ahead at the next state so in_ready is a pure flop.
    in_ready_d = (state_d != SB_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SB_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != SB_EMPTY);
  assign out_data  = head_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: opcode decode and datapath feeding
// a skid buffer that registers the result together with its zero flag.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  op_t              op_sel;
  logic [WIDTH-1:0] res_d;
  logic             zero_d;
  logic [WIDTH:0]   pay_in;
  logic [WIDTH:0]   pay_out;

  assign op_sel = op_t'(op);

  always_comb begin
    res_d = A;
    unique case (op_sel)
      OP_AND:  res_d = A & B;
      OP_OR:   res_d = A | B;
      OP_XOR:  res_d = A ^ B;
      OP_NOR:  res_d = ~(A | B);
      OP_NAND: res_d = ~(A & B);
      OP_XNOR: res_d = ~(A ^ B);
      OP_ANDN: res_d = A & ~B;
      OP_PASS: res_d = A;
    endcase
    zero_d = ~|res_d;
  end

  // zero travels with its result so it can never pair with a later entry.
  assign pay_in = {zero_d, res_d};

  skid_buf #(
    .W(WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (pay_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pay_out)
  );

  assign res  = pay_out[WIDTH-1:0];
  assign zero = pay_out[WIDTH];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: scoreboard monitor plus
// directed scenario tasks, including an 8-bit instance.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic        zero;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [2:0]  op8 = 3'd0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        out_valid8;
  logic [7:0]  res8;
  logic        zero8;

  int errors = 0;
  int checks = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .zero     (zero)
  );

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .op       (op8),
    .A        (a8),
    .B        (b8),
    .out_valid(out_valid8),
    .out_ready(1'b1),
    .res      (res8),
    .zero     (zero8)
  );

  function automatic logic [32:0] model(
    input logic [2:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    case (o)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a | b);
      3'd4:    r = ~(a & b);
      3'd5:    r = ~(a ^ b);
      3'd6:    r = a & ~b;
      default: r = a;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // Scoreboard: transfers are decided at the next rising edge, so
  // handshakes sampled on the falling edge predict them exactly.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_stale: res=%h zero=%b with no entry expected",
                   res, zero);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          if ({zero, res} !== e) begin
            errors++;
            $display("FAIL sb_order: got zero=%b res=%h want zero=%b res=%h",
                     zero, res, e[32], e[31:0]);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(op, A, B));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    op = 3'd7;
    A = 32'h1234_5678;
    tick();
    tick();
    checks++;
    if ({out_valid, in_ready, zero, res} !== 35'd0) begin
      errors++;
      $display("FAIL reset_state: ov=%b ir=%b z=%b res=%h want all 0",
               out_valid, in_ready, zero, res);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ir=%b ov=%b want ir=1 ov=0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_nor();
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = 3'd3;
    A = 32'h0000_FFFF;
    B = 32'h00FF_00FF;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || res !== 32'hFF00_0000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL nor: ov=%b res=%h z=%b want ov=1 res=ff000000 z=0",
               out_valid, res, zero);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL nor_drain: ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_xor_zero();
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = 3'd2;
    A = 32'hA5A5_A5A5;
    B = 32'hA5A5_A5A5;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || res !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL xor_zero: ov=%b res=%h z=%b want ov=1 res=0 z=1",
               out_valid, res, zero);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    A = 32'hF0F0_F0F0;
    B = 32'hFF00_FF00;
    op = 3'd0;
    tick();
    op = 3'd1;
    tick();
    op = 3'd6;
    checks++;
    if (in_ready !== 1'b0 || res !== 32'hF000_F000) begin
      errors++;
      $display("FAIL bp_full: ir=%b res=%h want ir=0 res=f000f000",
               in_ready, res);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0 || res !== 32'hF000_F000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL bp_stable: ir=%b res=%h z=%b want ir=0 res=f000f000",
               in_ready, res, zero);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || res !== 32'hFFF0_FFF0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: ov=%b res=%h ir=%b want 1 fff0fff0 1",
               out_valid, res, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || res !== 32'h00F0_00F0) begin
      errors++;
      $display("FAIL bp_third: ov=%b res=%h want ov=1 res=00f000f0",
               out_valid, res);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: ov=%b pending=%0d want 0 0",
               out_valid, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int ov_cnt;
    int ir_cnt;
    ov_cnt = 0;
    ir_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      op = 3'($urandom_range(0, 7));
      A = $urandom;
      B = (i % 10 == 3) ? A : $urandom;
      tick();
      if (out_valid) ov_cnt++;
      if (in_ready) ir_cnt++;
    end
    in_valid = 1'b0;
    checks++;
    if (ov_cnt != 100 || ir_cnt != 100) begin
      errors++;
      $display("FAIL stream: ov_cycles=%0d ir_cycles=%0d want 100 100",
               ov_cnt, ir_cnt);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: ov=%b pending=%0d want 0 0",
               out_valid, sb.size());
    end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 3'd7;
    A = 32'hDEAD_BEEF;
    tick();
    A = 32'hCAFE_F00D;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rf_full: ir=%b ov=%b want ir=0 ov=1",
               in_ready, out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || res !== 32'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rf_reset: ov=%b res=%h ir=%b want 0 0 0",
               out_valid, res, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rf_release: ir=%b ov=%b want ir=1 ov=0",
               in_ready, out_valid);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rf_stale: ov=%b res=%h want ov=0", out_valid, res);
    end
  endtask

  task automatic test_width8();
    in_valid8 = 1'b1;
    op8 = 3'd4;
    a8 = 8'hFF;
    b8 = 8'h0F;
    tick();
    in_valid8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b1 || res8 !== 8'hF0 || zero8 !== 1'b0) begin
      errors++;
      $display("FAIL w8_nand: ov=%b res=%h z=%b want ov=1 res=f0 z=0",
               out_valid8, res8, zero8);
    end
    tick();
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL w8_drain: ov=%b ir=%b want ov=0 ir=1",
               out_valid8, in_ready8);
    end
  endtask

  initial begin
    test_reset();
    test_nor();
    test_xor_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_full();
    test_width8();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
